// File: rtl/rv64_gpr_file_pkg.sv
// Shared constants and types for the RV64 integer register file.
//   ARCH_WIDTH : width of one architectural register
//   NUM_REGS   : number of architectural registers (x0..x31)
//   REG_ADDR_W : width of a register address
//   reg_addr_t : register address type
package rv64_gpr_file_pkg;

  localparam int ARCH_WIDTH = 64;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rv64_gpr_file_mux.sv
// Generic INPUT_QUANTITY-to-1 combinational multiplexer.
// Ports:
//   inputs  unpacked array of INPUT_QUANTITY words, ARCH_WIDTH bits each
//   sel     index of the word to forward
//   out     selected word (zero if sel is beyond INPUT_QUANTITY)
module rv64_gpr_file_mux #(
  parameter int ARCH_WIDTH     = 64,
  parameter int INPUT_QUANTITY = 32,
  parameter int SEL_WIDTH      = 5
) (
  input  logic [ARCH_WIDTH-1:0] inputs [INPUT_QUANTITY],
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [ARCH_WIDTH-1:0] out
);

  // Compare-and-select form stays well defined even when INPUT_QUANTITY
  // is not a power of two: an unmatched select yields zero, never X.
  always_comb begin
    out = '0;
    for (int i = 0; i < INPUT_QUANTITY; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        out = inputs[i];
      end
    end
  end

endmodule

// File: rtl/rv64_gpr_file_register.sv
// One ARCH_WIDTH-bit storage element of the register file.
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, loads START_VAL
//   writeEnable load writeData on the next rising edge
//   readOnly    when high, writes are ignored (used for x0)
//   writeData   value to store
//   readData    current stored value
module rv64_gpr_file_register
  import rv64_gpr_file_pkg::*;
#(
  parameter logic [ARCH_WIDTH-1:0] START_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEnable,
  input  logic                  readOnly,
  input  logic [ARCH_WIDTH-1:0] writeData,
  output logic [ARCH_WIDTH-1:0] readData
);

  logic [ARCH_WIDTH-1:0] value;

  // Reset wins over any write; a read-only entry keeps its reset value forever.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= START_VAL;
    end else if (writeEnable && !readOnly) begin
      value <= writeData;
    end
  end

  assign readData = value;

endmodule

// File: rtl/rv64_gpr_file.sv
// Integer general-purpose register file of the single-cycle RV64 core.
// Two combinational read ports, one clocked write port, x0 hard-wired to zero.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, all entries load START_VAL
//   rs1, rs2  read addresses
//   rd        write address
//   wEn       write enable
//   immediate decode hint, reserved, affects no output
//   wData     write data
//   out1      contents of register rs1
//   out2      contents of register rs2
//   dbg_regs  all registers flattened, entry i at [i*ARCH_WIDTH +: ARCH_WIDTH]
module rv64_gpr_file
  import rv64_gpr_file_pkg::*;
#(
  parameter logic [ARCH_WIDTH-1:0] START_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  reg_addr_t                      rs1,
  input  reg_addr_t                      rs2,
  input  reg_addr_t                      rd,
  input  logic                           wEn,
  input  logic                           immediate,
  input  logic [ARCH_WIDTH-1:0]          wData,
  output logic [ARCH_WIDTH-1:0]          out1,
  output logic [ARCH_WIDTH-1:0]          out2,
  output logic [NUM_REGS*ARCH_WIDTH-1:0] dbg_regs
);

  logic [NUM_REGS-1:0]   write_sel;
  logic [ARCH_WIDTH-1:0] reg_values [NUM_REGS];
  logic                  unused_immediate;

  assign unused_immediate = immediate;

  // One-hot write decode; bit 0 is never set so x0 cannot be written.
  always_comb begin
    write_sel = '0;
    if (wEn && (rd != '0)) begin
      write_sel[rd] = 1'b1;
    end
  end

  // x0 is read-only and always resets to zero regardless of START_VAL.
  rv64_gpr_file_register #(
    .START_VAL ('0)
  ) u_reg_zero (
    .clk         (clk),
    .rst         (rst),
    .writeEnable (write_sel[0]),
    .readOnly    (1'b1),
    .writeData   (wData),
    .readData    (reg_values[0])
  );

  for (genvar i = 1; i < NUM_REGS; i++) begin : g_regs
    rv64_gpr_file_register #(
      .START_VAL (START_VAL)
    ) u_reg (
      .clk         (clk),
      .rst         (rst),
      .writeEnable (write_sel[i]),
      .readOnly    (1'b0),
      .writeData   (wData),
      .readData    (reg_values[i])
    );
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dbg
    assign dbg_regs[i*ARCH_WIDTH +: ARCH_WIDTH] = reg_values[i];
  end

  rv64_gpr_file_mux #(
    .ARCH_WIDTH     (ARCH_WIDTH),
    .INPUT_QUANTITY (NUM_REGS),
    .SEL_WIDTH      (REG_ADDR_W)
  ) u_mux_rs1 (
    .inputs (reg_values),
    .sel    (rs1),
    .out    (out1)
  );

  rv64_gpr_file_mux #(
    .ARCH_WIDTH     (ARCH_WIDTH),
    .INPUT_QUANTITY (NUM_REGS),
    .SEL_WIDTH      (REG_ADDR_W)
  ) u_mux_rs2 (
    .inputs (reg_values),
    .sel    (rs2),
    .out    (out2)
  );

endmodule

// File: tb/tb_rv64_gpr_file.sv
// Directed self-checking bench for rv64_gpr_file.
module tb_rv64_gpr_file;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [4:0]    rd;
  logic          wEn;
  logic          immediate;
  logic [63:0]   wData;
  logic [63:0]   out1;
  logic [63:0]   out2;
  logic [2047:0] dbg_regs;

  logic [63:0]   model [32];
  logic [2047:0] exp_flat;
  int            passed;
  int            total;

  rv64_gpr_file dut (
    .clk       (clk),
    .rst       (rst),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .wEn       (wEn),
    .immediate (immediate),
    .wData     (wData),
    .out1      (out1),
    .out2      (out2),
    .dbg_regs  (dbg_regs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives one write and waits until just after the capturing edge.
  task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
    rd    = addr;
    wData = data;
    wEn   = 1'b1;
    @(posedge clk);
    #1;
    wEn = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    wEn   = 1'b1;
    rd    = 5'd5;
    wData = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wEn = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      rs2 = 5'(31 - i);
      #1;
      total++;
      if (out1 !== 64'd0) $display("[TB] FAIL reset_out1 x%0d got %h want 0", i, out1);
      else passed++;
      total++;
      if (out2 !== 64'd0) $display("[TB] FAIL reset_out2 x%0d got %h want 0", 31 - i, out2);
      else passed++;
    end
    total++;
    if (dbg_regs !== '0) $display("[TB] FAIL reset_dbg got nonzero want 0");
    else passed++;
    rs1 = 5'd5;
    #1;
    total++;
    if (out1 !== 64'd0) $display("[TB] FAIL reset_priority_x5 got %h want 0", out1);
    else passed++;
  endtask

  task automatic test_basic_write;
    do_write(5'd1, 64'h0123_4567_89AB_CDEF);
    do_write(5'd31, 64'h8000_0000_0000_0001);
    rs1 = 5'd1;
    rs2 = 5'd31;
    #1;
    total++;
    if (out1 !== 64'h0123_4567_89AB_CDEF)
      $display("[TB] FAIL basic_out1 got %h want 0123456789abcdef", out1);
    else passed++;
    total++;
    if (out2 !== 64'h8000_0000_0000_0001)
      $display("[TB] FAIL basic_out2 got %h want 8000000000000001", out2);
    else passed++;
    for (int i = 2; i < 31; i++) begin
      rs1 = 5'(i);
      #1;
      total++;
      if (out1 !== 64'd0) $display("[TB] FAIL basic_other x%0d got %h want 0", i, out1);
      else passed++;
    end
  endtask

  task automatic test_x0;
    do_write(5'd0, 64'h0000_0000_DEAD_BEEF);
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    total++;
    if (out1 !== 64'd0) $display("[TB] FAIL x0_out1 got %h want 0", out1);
    else passed++;
    total++;
    if (out2 !== 64'd0) $display("[TB] FAIL x0_out2 got %h want 0", out2);
    else passed++;
    total++;
    if (dbg_regs[63:0] !== 64'd0) $display("[TB] FAIL x0_dbg got %h want 0", dbg_regs[63:0]);
    else passed++;
  endtask

  task automatic test_wen_low;
    rd    = 5'd3;
    wData = 64'h55;
    wEn   = 1'b0;
    @(posedge clk);
    #1;
    rs1 = 5'd3;
    #1;
    total++;
    if (out1 !== 64'd0) $display("[TB] FAIL wen_low_x3 got %h want 0", out1);
    else passed++;
  endtask

  task automatic test_same_cycle;
    do_write(5'd7, 64'h11);
    rs1   = 5'd7;
    rd    = 5'd7;
    wData = 64'h22;
    wEn   = 1'b1;
    #1;
    total++;
    if (out1 !== 64'h11) $display("[TB] FAIL same_cycle_before got %h want 11", out1);
    else passed++;
    @(posedge clk);
    #1;
    wEn = 1'b0;
    model[7] = 64'h22;
    total++;
    if (out1 !== 64'h22) $display("[TB] FAIL same_cycle_after got %h want 22", out1);
    else passed++;
  endtask

  task automatic test_walking;
    for (int i = 1; i < 32; i++) do_write(5'(i), 64'(i) * 64'h0101_0101_0101_0101);
    for (int i = 0; i < 32; i++) exp_flat[i*64 +: 64] = model[i];
    total++;
    if (dbg_regs !== exp_flat) $display("[TB] FAIL walk_dbg got %h want %h", dbg_regs[127:0], exp_flat[127:0]);
    else passed++;
    for (int n = 0; n < 40; n++) begin
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      if (n == 0) rs2 = rs1;
      for (int imm = 0; imm < 2; imm++) begin
        immediate = imm[0];
        #1;
        total++;
        if (out1 !== model[rs1])
          $display("[TB] FAIL walk_out1 x%0d imm=%0d got %h want %h", rs1, imm, out1, model[rs1]);
        else passed++;
        total++;
        if (out2 !== model[rs2])
          $display("[TB] FAIL walk_out2 x%0d imm=%0d got %h want %h", rs2, imm, out2, model[rs2]);
        else passed++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    rst       = 1'b1;
    rs1       = 5'd0;
    rs2       = 5'd0;
    rd        = 5'd0;
    wEn       = 1'b0;
    immediate = 1'b0;
    wData     = 64'd0;
    test_reset;
    test_basic_write;
    test_x0;
    test_wen_low;
    test_same_cycle;
    test_walking;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
